// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver / host read port and the receive FIFO.
// The FIFO side uses the slave modport; the driving side uses master.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  RxDone;
  logic [7:0]            RxData;
  logic                  ParityError;
  logic                  FrameError;
  logic                  RxTimeOut;
  logic                  FifoClr;
  logic                  RdEn;
  logic [7:0]            RdData;
  logic                  RdPE;
  logic                  RdFE;
  logic [DEPTH_LOG2:0]   Level;
  logic                  Empty;
  logic                  Full;
  logic [DEPTH_LOG2:0]   TrigLevel;
  logic                  OvrClr;
  logic                  Overrun;
  logic                  TimeoutFlag;
  logic                  RxIrq;

  modport master (
    output RxDone, RxData, ParityError, FrameError, RxTimeOut,
    output FifoClr, RdEn, TrigLevel, OvrClr,
    input  RdData, RdPE, RdFE, Level, Empty, Full,
    input  Overrun, TimeoutFlag, RxIrq
  );

  modport slave (
    input  RxDone, RxData, ParityError, FrameError, RxTimeOut,
    input  FifoClr, RdEn, TrigLevel, OvrClr,
    output RdData, RdPE, RdFE, Level, Empty, Full,
    output Overrun, TimeoutFlag, RxIrq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures one entry per RxDone rising edge, show-ahead read port,
// sticky overrun/idle-timeout flags and interrupt. Macro UART_RX_ERR_STATUS_EN keeps per-byte error bits.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  uart_rx_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);

`ifdef UART_RX_ERR_STATUS_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    wrEntry;
  logic [ENTRY_W-1:0]    headEntry;

  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2-1:0] wrPtrNext, rdPtrNext;
  logic [DEPTH_LOG2:0]   level, levelNext;

  logic rxDonePrev;
  logic primed;
  logic wrStb;
  logic empty, full;
  logic pop, push, ovrSet;

  logic overrun, overrunNext;
  logic timeoutFlag, timeoutNext;
  logic rxIrq, rxIrqNext;
  logic levelIrq;

  // primed stays low for the first post-reset cycle so a frame already
  // signalled when reset released is absorbed into rxDonePrev, not written.
  assign wrStb = primed & bus.RxDone & ~rxDonePrev;

  assign empty  = (level == '0);
  assign full   = (level == LVL_FULL);
  assign pop    = bus.RdEn & ~empty;
  assign push   = wrStb & (~full | pop);
  assign ovrSet = wrStb & full & ~pop;

  always_comb begin
    levelNext = level;
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    if (bus.FifoClr) begin
      levelNext = '0;
      wrPtrNext = '0;
      rdPtrNext = '0;
    end else begin
      if (push) wrPtrNext = wrPtr + 1'b1;
      if (pop)  rdPtrNext = rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   levelNext = level + LVL_ONE;
        2'b01:   levelNext = level - LVL_ONE;
        default: levelNext = level;
      endcase
    end
  end

  always_comb begin
    overrunNext = overrun;
    if (bus.FifoClr)     overrunNext = 1'b0;
    else if (ovrSet)     overrunNext = 1'b1;
    else if (bus.OvrClr) overrunNext = 1'b0;
  end

  // A timeout seen together with the pop of the last entry leaves nothing to
  // report, so set only wins while the FIFO stays non-empty.
  always_comb begin
    timeoutNext = timeoutFlag;
    if (bus.FifoClr)
      timeoutNext = 1'b0;
    else if (bus.RxTimeOut && !empty && (levelNext != '0))
      timeoutNext = 1'b1;
    else if (pop)
      timeoutNext = 1'b0;
  end

  always_comb begin
    levelIrq  = (bus.TrigLevel != '0) && (levelNext >= bus.TrigLevel);
    rxIrqNext = levelIrq | timeoutNext | overrunNext;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      level       <= '0;
      rxDonePrev  <= 1'b0;
      primed      <= 1'b0;
      overrun     <= 1'b0;
      timeoutFlag <= 1'b0;
      rxIrq       <= 1'b0;
    end else begin
      wrPtr       <= wrPtrNext;
      rdPtr       <= rdPtrNext;
      level       <= levelNext;
      rxDonePrev  <= bus.RxDone;
      primed      <= 1'b1;
      overrun     <= overrunNext;
      timeoutFlag <= timeoutNext;
      rxIrq       <= rxIrqNext;
    end
  end

`ifdef UART_RX_ERR_STATUS_EN
  assign wrEntry = {bus.FrameError, bus.ParityError, bus.RxData};
`else
  logic unusedErrBits;
  assign wrEntry       = bus.RxData;
  assign unusedErrBits = bus.ParityError ^ bus.FrameError;
`endif

  // Storage is not reset; the head value after reset or flush is stale data.
  always_ff @(posedge CLK) begin
    if (push && !bus.FifoClr) mem[wrPtr] <= wrEntry;
  end

  assign headEntry = mem[rdPtr];
  assign bus.RdData = headEntry[7:0];

`ifdef UART_RX_ERR_STATUS_EN
  assign bus.RdPE = headEntry[8];
  assign bus.RdFE = headEntry[9];
`else
  assign bus.RdPE = 1'b0;
  assign bus.RdFE = 1'b0;
`endif

  assign bus.Level       = level;
  assign bus.Empty       = empty;
  assign bus.Full        = full;
  assign bus.Overrun     = overrun;
  assign bus.TimeoutFlag = timeoutFlag;
  assign bus.RxIrq       = rxIrq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a table of write/pop vectors plus hand
// sequences for held RxDone, overrun, full bypass, interrupts, errors and flush.
module tb_uart_rx_fifo;

  localparam int DL2 = 4;

`ifdef UART_RX_ERR_STATUS_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic CLK;
  logic RESETn;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         isPop;
    logic [7:0] data;
    int         expLevel;
    int         expHead;
    int         expEmpty;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic writeByte(input logic [7:0] d, input logic pe, input logic fe);
    bus.RxData      = d;
    bus.ParityError = pe;
    bus.FrameError  = fe;
    bus.RxDone      = 1'b1;
    tick();
    bus.RxDone      = 1'b0;
    tick();
  endtask

  task automatic popOne();
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b0, 8'h41, 1, 'h41, 0};
    vecs[1] = '{1'b0, 8'h42, 2, 'h41, 0};
    vecs[2] = '{1'b0, 8'h43, 3, 'h41, 0};
    vecs[3] = '{1'b1, 8'h00, 2, 'h42, 0};
    vecs[4] = '{1'b1, 8'h00, 1, 'h43, 0};
    vecs[5] = '{1'b1, 8'h00, 0, 0,    1};

    RESETn          = 1'b0;
    bus.RxDone      = 1'b0;
    bus.RxData      = 8'h00;
    bus.ParityError = 1'b0;
    bus.FrameError  = 1'b0;
    bus.RxTimeOut   = 1'b0;
    bus.FifoClr     = 1'b0;
    bus.RdEn        = 1'b0;
    bus.TrigLevel   = '0;
    bus.OvrClr      = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    tick();

    check("reset Level", int'(bus.Level), 0);
    check("reset Empty", int'(bus.Empty), 1);
    check("reset Full", int'(bus.Full), 0);
    check("reset Overrun", int'(bus.Overrun), 0);
    check("reset TimeoutFlag", int'(bus.TimeoutFlag), 0);
    check("reset RxIrq", int'(bus.RxIrq), 0);

    // Basic write/pop sequence from the vector table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].isPop) popOne();
      else writeByte(vecs[i].data, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d Level", i), int'(bus.Level), vecs[i].expLevel);
      check($sformatf("vec%0d Empty", i), int'(bus.Empty), vecs[i].expEmpty);
      if (vecs[i].expEmpty == 0)
        check($sformatf("vec%0d RdData", i), int'(bus.RdData), vecs[i].expHead);
    end

    // RxDone held high for 50 cycles stores a single entry
    bus.RxData = 8'h55;
    bus.RxDone = 1'b1;
    repeat (50) tick();
    bus.RxDone = 1'b0;
    tick();
    check("held Level", int'(bus.Level), 1);
    check("held RdData", int'(bus.RdData), 'h55);
    popOne();
    tick();
    check("held drained Empty", int'(bus.Empty), 1);

    // Reset released while RxDone is already high must not write
    bus.RxData = 8'h99;
    bus.RxDone = 1'b1;
    RESETn     = 1'b0;
    tick();
    RESETn = 1'b1;
    repeat (3) tick();
    check("rst-high Level", int'(bus.Level), 0);
    bus.RxDone = 1'b0;
    tick();
    check("rst-high Empty", int'(bus.Empty), 1);

    // 17 writes: 16 fill, 17th overruns
    for (int i = 0; i < 16; i++) writeByte(8'h10 + 8'(i), 1'b0, 1'b0);
    check("fill Full", int'(bus.Full), 1);
    check("fill Level", int'(bus.Level), 16);
    check("fill Overrun", int'(bus.Overrun), 0);
    check("fill Empty", int'(bus.Empty), 0);
    writeByte(8'hEE, 1'b0, 1'b0);
    check("ovr Level", int'(bus.Level), 16);
    check("ovr Overrun", int'(bus.Overrun), 1);
    check("ovr RxIrq", int'(bus.RxIrq), 1);
    check("ovr head", int'(bus.RdData), 'h10);
    bus.OvrClr = 1'b1;
    tick();
    bus.OvrClr = 1'b0;
    tick();
    check("ovrclr Overrun", int'(bus.Overrun), 0);
    check("ovrclr RxIrq", int'(bus.RxIrq), 0);

    // Full with write strobe and pop in the same cycle
    bus.RxData = 8'hAA;
    bus.RxDone = 1'b1;
    bus.RdEn   = 1'b1;
    tick();
    bus.RxDone = 1'b0;
    bus.RdEn   = 1'b0;
    tick();
    check("bypass Level", int'(bus.Level), 16);
    check("bypass Overrun", int'(bus.Overrun), 0);
    check("bypass head", int'(bus.RdData), 'h11);
    for (int i = 0; i < 15; i++) popOne();
    tick();
    check("bypass tail Level", int'(bus.Level), 1);
    check("bypass tail data", int'(bus.RdData), 'hAA);
    popOne();
    tick();
    check("bypass drained Empty", int'(bus.Empty), 1);

    // Level interrupt and idle timeout
    bus.TrigLevel = 5'd4;
    for (int i = 0; i < 3; i++) writeByte(8'h01 + 8'(i), 1'b0, 1'b0);
    tick();
    check("trig below RxIrq", int'(bus.RxIrq), 0);
    writeByte(8'h04, 1'b0, 1'b0);
    tick();
    check("trig at RxIrq", int'(bus.RxIrq), 1);
    popOne();
    tick();
    check("trig pop RxIrq", int'(bus.RxIrq), 0);
    popOne();
    popOne();
    tick();
    check("to pre Level", int'(bus.Level), 1);
    bus.RxTimeOut = 1'b1;
    tick();
    bus.RxTimeOut = 1'b0;
    tick();
    check("to TimeoutFlag", int'(bus.TimeoutFlag), 1);
    check("to RxIrq", int'(bus.RxIrq), 1);
    popOne();
    tick();
    check("to pop TimeoutFlag", int'(bus.TimeoutFlag), 0);
    check("to pop RxIrq", int'(bus.RxIrq), 0);
    bus.RxTimeOut = 1'b1;
    tick();
    bus.RxTimeOut = 1'b0;
    tick();
    check("to empty TimeoutFlag", int'(bus.TimeoutFlag), 0);
    writeByte(8'h05, 1'b0, 1'b0);
    bus.RxTimeOut = 1'b1;
    bus.RdEn      = 1'b1;
    tick();
    bus.RxTimeOut = 1'b0;
    bus.RdEn      = 1'b0;
    tick();
    check("to last-pop TimeoutFlag", int'(bus.TimeoutFlag), 0);
    check("to last-pop Level", int'(bus.Level), 0);
    bus.TrigLevel = '0;

    // Error status bits
    writeByte(8'h7E, 1'b1, 1'b0);
    writeByte(8'h11, 1'b0, 1'b1);
    check("err head", int'(bus.RdData), 'h7E);
    check("err RdPE", int'(bus.RdPE), ERR_EN);
    check("err RdFE", int'(bus.RdFE), 0);
    popOne();
    tick();
    check("err2 head", int'(bus.RdData), 'h11);
    check("err2 RdPE", int'(bus.RdPE), 0);
    check("err2 RdFE", int'(bus.RdFE), ERR_EN);

    // Flush mid-stream with a simultaneous write strobe
    writeByte(8'h21, 1'b0, 1'b0);
    check("preclr Level", int'(bus.Level), 2);
    bus.RxData  = 8'h22;
    bus.RxDone  = 1'b1;
    bus.FifoClr = 1'b1;
    tick();
    bus.RxDone  = 1'b0;
    bus.FifoClr = 1'b0;
    tick();
    check("clr Level", int'(bus.Level), 0);
    check("clr Empty", int'(bus.Empty), 1);
    check("clr Full", int'(bus.Full), 0);

    // Pop on empty is ignored; pointers stay aligned
    popOne();
    tick();
    check("emptypop Level", int'(bus.Level), 0);
    check("emptypop Empty", int'(bus.Empty), 1);
    writeByte(8'h33, 1'b0, 1'b0);
    check("after emptypop Level", int'(bus.Level), 1);
    check("after emptypop head", int'(bus.RdData), 'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
